// File: rtl/spi_master.sv
// Mode-0 SPI master: one COUNT_BITS word per accepted start, MSB first on mosi, MSB first from miso.
// Frame sequence LEAD -> SHIFT -> TRAIL -> GAP; every phase and sck half-period is CLK_DIV clk cycles.
module spi_master #(
  parameter int COUNT_BITS = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [COUNT_BITS-1:0] tx_data,
  output logic [COUNT_BITS-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  ssel
);

  localparam int               BIT_W       = $clog2(COUNT_BITS);
  localparam logic [7:0]       HALF_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(COUNT_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            half_cnt_q, half_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [COUNT_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [COUNT_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [COUNT_BITS-1:0] rx_data_q, rx_data_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  ssel_q, ssel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic half_done;
  logic sck_rise;
  logic sck_fall;
  logic last_fall;

  // The end of LEAD doubles as the first sck rise, so SHIFT opens with sck already high.
  assign half_done = (half_cnt_q == 8'd0);
  assign sck_rise  = half_done && ((state_q == LEAD) || ((state_q == SHIFT) && !sck_q));
  assign sck_fall  = half_done && (state_q == SHIFT) && sck_q;
  assign last_fall = sck_fall && (bit_cnt_q == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ssel_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ssel_q     <= ssel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)     state_d = LEAD;
      LEAD:    if (half_done) state_d = SHIFT;
      SHIFT:   if (last_fall) state_d = TRAIL;
      TRAIL:   if (half_done) state_d = GAP;
      GAP:     if (half_done) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    ssel_d     = ssel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Reloading on every expiry also covers every state change, so frames never drift.
    if ((state_q == IDLE) || half_done) begin
      half_cnt_d = HALF_RELOAD;
    end else begin
      half_cnt_d = half_cnt_q - 8'd1;
    end

    if (sck_rise) begin
      sck_d      = 1'b1;
      rx_shift_d = {rx_shift_q[COUNT_BITS-2:0], miso};
    end

    if (sck_fall) begin
      sck_d = 1'b0;
      if (!last_fall) begin
        mosi_d     = tx_shift_q[COUNT_BITS-1];
        tx_shift_d = tx_shift_q << 1;
        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_shift_d = tx_data << 1;
          mosi_d     = tx_data[COUNT_BITS-1];
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          sck_d      = 1'b0;
          ssel_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      TRAIL: begin
        if (half_done) begin
          ssel_d    = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_shift_q;
        end
      end
      GAP: begin
        if (half_done) begin
          busy_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign ssel    = ssel_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master: two instances (32-bit/div 4 and 8-bit/div 2) against a
// frame-timing model derived from the cycle formulas, with a mode-0 slave that answers on miso.
`timescale 1ns/1ps
module tb_spi_master;

  logic        clk = 1'b0;
  logic        rst_n, start, sel;
  logic [63:0] tx_data;
  logic        miso;

  logic [31:0] rx_l;
  logic        busy_l, done_l, sck_l, mosi_l, ssel_l, start_l;
  logic [7:0]  rx_s;
  logic        busy_s, done_s, sck_s, mosi_s, ssel_s, start_s;

  assign start_l = start & ~sel;
  assign start_s = start & sel;

  spi_master #(.COUNT_BITS(32), .CLK_DIV(4)) dut_l (
    .clk(clk), .rst_n(rst_n), .start(start_l), .tx_data(tx_data[31:0]), .rx_data(rx_l),
    .busy(busy_l), .done(done_l), .sck(sck_l), .mosi(mosi_l), .miso(miso), .ssel(ssel_l));

  spi_master #(.COUNT_BITS(8), .CLK_DIV(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .tx_data(tx_data[7:0]), .rx_data(rx_s),
    .busy(busy_s), .done(done_s), .sck(sck_s), .mosi(mosi_s), .miso(miso), .ssel(ssel_s));

  always #5 clk = ~clk;

  logic [63:0] rx_w;
  logic        busy_w, done_w, sck_w, mosi_w, ssel_w;
  int          cur_n, cur_d;
  assign rx_w   = sel ? {56'd0, rx_s} : {32'd0, rx_l};
  assign busy_w = sel ? busy_s : busy_l;
  assign done_w = sel ? done_s : done_l;
  assign sck_w  = sel ? sck_s  : sck_l;
  assign mosi_w = sel ? mosi_s : mosi_l;
  assign ssel_w = sel ? ssel_s : ssel_l;
  assign cur_n  = sel ? 8 : 32;
  assign cur_d  = sel ? 2 : 4;

  // Mode-0 slave: MSB ready when ssel falls, next bit after each sck fall.
  logic [63:0] sl_word = '0;
  int          sl_idx = 0;
  int          mmode = 0;
  logic        slave_bit;
  always @(negedge ssel_w) sl_idx = 0;
  always @(negedge sck_w) if (!ssel_w) sl_idx = sl_idx + 1;
  always_comb begin
    slave_bit = 1'b0;
    if (sl_idx < cur_n) slave_bit = sl_word[cur_n-1-sl_idx];
  end
  always_comb begin
    case (mmode)
      1:       miso = mosi_w;
      2:       miso = 1'b0;
      3:       miso = 1'b1;
      default: miso = slave_bit;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed events, cycle-numbered with 1 = first cycle after the accepting edge.
  int          rise_q[$], done_q[$], bfall_q[$], sfall_q[$], srise_q[$], pulse_q[$];
  logic        mbit_q[$];
  logic [63:0] drx_q[$];
  int          bad_mosi, bad_rx;
  int          hold_end = 1;
  logic [63:0] tx_after = '0;

  // Expected frames: start offset, transmitted word, word the receiver should end up with.
  int          exp_off[$];
  logic [63:0] exp_tx[$], exp_rx[$];

  task automatic observe(input int ncyc);
    logic p_sck, p_ssel, p_busy, p_mosi;
    logic [63:0] p_rx;
    rise_q.delete(); done_q.delete(); bfall_q.delete(); sfall_q.delete(); srise_q.delete();
    mbit_q.delete(); drx_q.delete();
    bad_mosi = 0; bad_rx = 0;
    p_sck = sck_w; p_ssel = ssel_w; p_busy = busy_w; p_mosi = mosi_w; p_rx = rx_w;
    @(posedge clk);
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (sck_w && !p_sck) begin rise_q.push_back(i); mbit_q.push_back(mosi_w); end
      if (done_w) begin done_q.push_back(i); drx_q.push_back(rx_w); end
      if (!busy_w && p_busy) bfall_q.push_back(i);
      if (!ssel_w && p_ssel) sfall_q.push_back(i);
      if (ssel_w && !p_ssel) srise_q.push_back(i);
      if ((mosi_w !== p_mosi) && !(p_sck && !sck_w) && !(!ssel_w && p_ssel)) bad_mosi++;
      if ((rx_w !== p_rx) && !done_w) bad_rx++;
      p_sck = sck_w; p_ssel = ssel_w; p_busy = busy_w; p_mosi = mosi_w; p_rx = rx_w;
      start = (i < hold_end);
      foreach (pulse_q[j]) if (pulse_q[j] == i) start = 1'b1;
      if (i == 1) tx_data = tx_after;
    end
    start = 1'b0;
  endtask

  task automatic verify(input string nm);
    int n, d, o, idx, bad_rise;
    logic [63:0] w, mask;
    n = cur_n; d = cur_d;
    mask = (64'd1 << n) - 64'd1;
    check_val({nm, ".n_rise"},  rise_q.size(),  exp_off.size() * n);
    check_val({nm, ".n_done"},  done_q.size(),  exp_off.size());
    check_val({nm, ".n_bfall"}, bfall_q.size(), exp_off.size());
    check_val({nm, ".n_sfall"}, sfall_q.size(), exp_off.size());
    foreach (exp_off[f]) begin
      o = exp_off[f];
      check_val({nm, ".ssel_fall"}, (f < sfall_q.size()) ? sfall_q[f] : -1, o + 1);
      check_val({nm, ".ssel_rise"}, (f < srise_q.size()) ? srise_q[f] : -1, o + 1 + (2*n+1)*d);
      check_val({nm, ".done_cyc"},  (f < done_q.size())  ? done_q[f]  : -1, o + 1 + (2*n+1)*d);
      check_val({nm, ".rx"},        (f < drx_q.size())   ? drx_q[f]   : ~64'd0, exp_rx[f] & mask);
      check_val({nm, ".busy_fall"}, (f < bfall_q.size()) ? bfall_q[f] : -1, o + 1 + (2*n+2)*d);
      w = '0; bad_rise = 0;
      for (int k = 0; k < n; k++) begin
        idx = f*n + k;
        if (idx < rise_q.size()) begin
          w = {w[62:0], mbit_q[idx]};
          if (rise_q[idx] != o + 1 + (2*k+1)*d) bad_rise++;
        end else begin
          bad_rise++;
        end
      end
      check_val({nm, ".mosi_word"}, w, exp_tx[f] & mask);
      check_val({nm, ".rise_timing_errs"}, bad_rise, 0);
    end
    check_val({nm, ".mosi_off_fall"}, bad_mosi, 0);
    check_val({nm, ".rx_partial"}, bad_rx, 0);
  endtask

  task automatic launch(input logic [63:0] tx, input logic [63:0] sw, input int mode);
    @(negedge clk);
    tx_data = tx; sl_word = sw; mmode = mode; start = 1'b1;
  endtask

  task automatic single(input string nm, input logic [63:0] tx, input logic [63:0] sw,
                        input int mode, input logic [63:0] erx, input int ncyc);
    tx_after = {$urandom(), $urandom()};
    launch(tx, sw, mode);
    observe(ncyc);
    exp_off.delete(); exp_tx.delete(); exp_rx.delete();
    exp_off.push_back(0); exp_tx.push_back(tx); exp_rx.push_back(erx);
    verify(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t1, t2, sw;
    int n_d, p;
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.ssel_l", ssel_l, 1); check_val("rst.sck_l", sck_l, 0);
    check_val("rst.mosi_l", mosi_l, 0); check_val("rst.busy_l", busy_l, 0);
    check_val("rst.done_l", done_l, 0); check_val("rst.rx_l", rx_l, 0);
    check_val("rst.ssel_s", ssel_s, 1); check_val("rst.rx_s", rx_s, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    single("f1", 64'hA5C3_0F81, 64'h1234_5678, 0, 64'h1234_5678, 275);
    check_val("f1.done_at_261", (done_q.size() > 0) ? done_q[0] : -1, 261);
    check_val("f1.busy_fall_265", (bfall_q.size() > 0) ? bfall_q[0] : -1, 265);
    check_val("f1.rx_held", rx_w, 64'h1234_5678);

    for (int r = 0; r < 3; r++) begin
      t1 = {32'd0, $urandom()}; sw = {32'd0, $urandom()};
      single("rnd32", t1, sw, 0, sw, 275);
    end

    // Back-to-back with start held; the second word is presented only after the first capture.
    t1 = {32'd0, $urandom()}; t2 = {32'd0, $urandom()}; sw = {32'd0, $urandom()};
    tx_after = t2; hold_end = 300;
    launch(t1, sw, 0);
    observe(540);
    hold_end = 1;
    p = (2*32 + 2)*4 + 1;
    exp_off.delete(); exp_tx.delete(); exp_rx.delete();
    exp_off.push_back(0); exp_tx.push_back(t1); exp_rx.push_back(sw);
    exp_off.push_back(p); exp_tx.push_back(t2); exp_rx.push_back(sw);
    verify("b2b");
    check_val("b2b.ssel_after_busy",
              (sfall_q.size() > 1 && bfall_q.size() > 0) ? sfall_q[1] - bfall_q[0] : -1, 1);
    check_val("b2b.ssel_high_ge_div1",
              (sfall_q.size() > 1 && srise_q.size() > 0) ? (sfall_q[1] - srise_q[0] >= 5) : 0, 1);

    pulse_q = '{10, 100, 264};
    t1 = {32'd0, $urandom()}; sw = {32'd0, $urandom()};
    single("busy_start", t1, sw, 0, sw, 300);
    pulse_q.delete();

    single("loop", 64'h8000_0001, 64'h0, 1, 64'h8000_0001, 275);

    // Abort mid-SHIFT, then restart on the very edge reset releases.
    t1 = {32'd0, $urandom()}; sw = {32'd0, $urandom()};
    tx_after = t1;
    launch(t1, sw, 0);
    observe(120);
    check_val("rmid.ssel_before", ssel_w, 0);
    check_val("rmid.rx_before_nz", rx_w != 0, 1);
    rst_n = 1'b0;
    #1;
    check_val("rmid.ssel", ssel_w, 1); check_val("rmid.sck", sck_w, 0);
    check_val("rmid.busy", busy_w, 0); check_val("rmid.rx", rx_w, 0);
    check_val("rmid.mosi", mosi_w, 0); check_val("rmid.done", done_w, 0);
    n_d = 0;
    repeat (4) begin @(negedge clk); if (done_w) n_d++; end
    check_val("rmid.no_done", n_d, 0);
    rst_n = 1'b1;
    t1 = {32'd0, $urandom()}; sw = {32'd0, $urandom()};
    tx_data = t1; sl_word = sw; mmode = 0; start = 1'b1;
    tx_after = {$urandom(), $urandom()};
    observe(275);
    exp_off.delete(); exp_tx.delete(); exp_rx.delete();
    exp_off.push_back(0); exp_tx.push_back(t1); exp_rx.push_back(sw);
    verify("after_rst");

    @(negedge clk); sel = 1'b1;
    single("e_ff_m0", 64'hFF, 64'h0, 2, 64'h00, 45);
    check_val("e.done_at_35", (done_q.size() > 0) ? done_q[0] : -1, 35);
    single("e_00_m1", 64'h00, 64'h0, 3, 64'hFF, 45);
    for (int r = 0; r < 3; r++) begin
      t1 = {56'd0, 8'($urandom())}; sw = {56'd0, 8'($urandom())};
      single("rnd8", t1, sw, 0, sw, 45);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
